fib_bcd_display: RTL and testbench

//  Downstream display stage for the Fibonacci generator: accepts an N-bit binary value on a

---
 rtl/fib_bcd_display.sv | 161 ++++++++++++++++
 tb/tb_fib_bcd_display.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fib_bcd_display.sv
// Display stage for the Fibonacci generator: sequential double-dabble binary-to-BCD
// conversion feeding a multiplexed, active-low 7-segment display with leading-zero blanking.
module fib_bcd_display #(
  parameter int N           = 13,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  function automatic longint unsigned pow10(input int d);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned MAX_BIN = (64'd1 << N) - 64'd1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_check
      $fatal(1, "fib_bcd_display: DIGITS too small to hold 2**N-1");
    end
    if (REFRESH_DIV < 1) begin : g_refresh_check
      $fatal(1, "fib_bcd_display: REFRESH_DIV must be at least 1");
    end
  endgenerate

  typedef enum logic {IDLE, CONV} state_t;

  state_t                state_q, state_d;
  logic [N-1:0]          shift_q, shift_d;
  logic [4*DIGITS-1:0]   work_q, work_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  bcd_valid_q, bcd_valid_d;
  logic [RW-1:0]         refresh_q, refresh_d;
  logic [SW-1:0]         scan_q, scan_d;

  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   work_next;
  logic [DIGITS-1:0]     blank;
  logic                  hi_zero;
  logic [3:0]            digit_sel;

  // One double-dabble step: correct nibbles >= 5, then shift the next binary bit in.
  always_comb begin
    adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end
    work_next = {adj[4*DIGITS-2:0], shift_q[N-1]};
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    in_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d = bin;
          work_d  = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        work_d  = work_next;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          bcd_d       = work_next;
          bcd_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    scan_d    = scan_q;
    if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      scan_d    = (scan_q == SW'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end
  end

  // A digit is blanked only when it and every digit above it are zero; units never blank.
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero & (bcd_q[4*k +: 4] == 4'd0);
      if (k > 0 && BLANK_LZ != 0) blank[k] = hi_zero;
    end
    digit_sel = bcd_q[4*scan_q +: 4];
    seg = 7'b1111111;
    if (!blank[scan_q]) begin
      case (digit_sel)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
    an = ~(DIGITS'(1) << scan_q);
  end

  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      refresh_q   <= '0;
      scan_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      refresh_q   <= refresh_d;
      scan_q      <= scan_d;
    end
  end

endmodule

// File: tb/tb_fib_bcd_display.sv
// Scoreboard bench for fib_bcd_display: decimal reference model predicts conversions,
// handshake acceptance and the scanned display for blanking and non-blanking instances.
module tb_fib_bcd_display;

  localparam int N      = 13;
  localparam int DIGITS = 4;
  localparam int RD     = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [N-1:0] bin;
  logic        in_ready, in_ready_nb;
  logic [15:0] bcd, bcd_nb;
  logic        bcd_valid, bcd_valid_nb;
  logic [6:0]  seg, seg_nb;
  logic [3:0]  an, an_nb;

  fib_bcd_display #(.N(N), .DIGITS(DIGITS), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .bcd(bcd), .bcd_valid(bcd_valid), .seg(seg), .an(an));

  fib_bcd_display #(.N(N), .DIGITS(DIGITS), .REFRESH_DIV(RD), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nb), .bin(bin),
    .bcd(bcd_nb), .bcd_valid(bcd_valid_nb), .seg(seg_nb), .an(an_nb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          t_disp = 0;
  int          busy_cnt = 0;
  bit          started = 0;
  bit          acc_flag = 0;
  logic [15:0] pending = '0;
  logic [15:0] disp = '0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] val, input int s, input bit blank_lz);
    logic [15:0] upper;
    logic [3:0]  d;
    upper = val >> (4 * s);
    d = val[4*s +: 4];
    if (blank_lz && s > 0 && upper == 16'd0) return 7'b1111111;
    return seg_tab[d];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got event, expected none/other at cycle %0d", name, cyc);
  endtask

  // Reference model: a conversion takes N clocks after acceptance; nothing is accepted while busy.
  always @(posedge clk) begin
    cyc++;
    acc_flag = 0;
    if (reset) begin
      started  = 1;
      busy_cnt = 0;
      disp     = '0;
      t_disp   = 0;
      sb_q.delete();
    end else begin
      t_disp++;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) disp = pending;
      end else if (in_valid) begin
        pending  = to_bcd(int'(bin));
        busy_cnt = N;
        sb_q.push_back('{pending, cyc + N});
        acc_flag = 1;
      end
    end
  end

  // Monitor: scoreboard pop on bcd_valid plus continuous display/handshake checks.
  always @(negedge clk) begin
    exp_t e;
    int   s;
    if (started) begin
      check_output("in_ready", 32'(in_ready), 32'(busy_cnt == 0));
      check_output("bcd_hold", 32'(bcd), 32'(disp));
      if (bcd_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          flag_fail("spurious_bcd_valid");
        end else begin
          e = sb_q.pop_front();
          check_output("bcd_result", 32'(bcd), 32'(e.val));
          check_output("latency_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (bcd_valid !== 1'b0) begin
        check_output("bcd_valid_known", 32'(bcd_valid), 32'd0);
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        flag_fail("missing_bcd_valid");
        void'(sb_q.pop_front());
      end
      s = (t_disp / RD) % DIGITS;
      check_output("an", 32'(an), 32'(~(4'b0001 << s) & 4'hF));
      check_output("seg_blank", 32'(seg), 32'(exp_seg(disp, s, 1'b1)));
      check_output("an_nb", 32'(an_nb), 32'(~(4'b0001 << s) & 4'hF));
      check_output("seg_noblank", 32'(seg_nb), 32'(exp_seg(disp, s, 1'b0)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input bit valid, input int v, input bit rst);
    in_valid = valid;
    bin      = N'(v);
    reset    = rst;
  endtask

  task automatic offer(input int v);
    bit ok;
    ok = 0;
    apply_stimulus(1'b1, v, 1'b0);
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = acc_flag;
    end
    if (!ok) flag_fail("accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      done = (sb_q.size() == 0 && busy_cnt == 0);
    end
    if (!done) flag_fail("idle_timeout");
  endtask

  int fib_seq [13] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};

  initial begin
    apply_stimulus(1'b0, 0, 1'b1);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    offer(8191);
    offer(0);
    offer(5);
    offer(1000);
    wait_idle();

    in_valid = 1'b1;
    foreach (fib_seq[i]) begin
      bin = N'(fib_seq[i]);
      tick();
    end
    bin = N'(144);
    repeat (N + 2) tick();
    in_valid = 1'b0;
    wait_idle();

    offer(6765);
    repeat (4) tick();
    bin = N'(1234);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();

    offer(89);
    bin = N'(4321);
    wait_idle();
    repeat (40) tick();

    for (int i = 0; i < 300; i++) begin
      apply_stimulus($urandom_range(0, 2) != 0, int'($urandom_range(0, 8191)),
                     $urandom_range(0, 99) == 0);
      tick();
    end
    apply_stimulus(1'b0, 0, 1'b0);
    wait_idle();
    offer(8191);
    wait_idle();
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
